// File: rtl/pcpu_mem_responder_pkg.sv
// Shared definitions for the PCPU memory responder: default widths, the
// HALT instruction word and the byte-loader state encoding.
package pcpu_mem_responder_pkg;

  localparam int IADDR_W_DEF = 8;
  localparam int DADDR_W_DEF = 8;
  localparam int DATA_W_DEF  = 16;

  localparam logic [4:0]  OP_HALT   = 5'b00001;
  localparam logic [15:0] HALT_WORD = {OP_HALT, 11'b0};

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_HI     = 2'd1,
    LD_COMMIT = 2'd2,
    LD_DONE   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/pcpu_loader.sv
// Byte-serial instruction-memory loader: assembles little-endian 16-bit words,
// emits an imem write port, tracks word count / overflow and pulses start.
module pcpu_loader
  import pcpu_mem_responder_pkg::*;
#(
  parameter int IADDR_W = IADDR_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ld_valid_i,
  input  logic [7:0]         ld_data_i,
  input  logic               ld_last_i,
  output logic               ld_ready_o,
  output logic               ld_busy_o,
  output logic [IADDR_W:0]   ld_count_o,
  output logic               ld_ovf_o,
  output logic               start_o,
  output logic               we_o,
  output logic [IADDR_W-1:0] waddr_o,
  output logic [15:0]        wdata_o
);

  ld_state_e            state_q, state_d;
  logic                 lo_phase_q, lo_phase_d;
  logic [7:0]           lo_q, lo_d;
  logic [7:0]           hi_q, hi_d;
  logic                 last_q, last_d;
  logic [IADDR_W-1:0]   ptr_q, ptr_d;
  logic [IADDR_W:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= LD_IDLE;
      lo_phase_q <= 1'b0;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
      last_q     <= 1'b0;
      ptr_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_phase_q <= lo_phase_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      last_q     <= last_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lo_phase_d = lo_phase_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    last_d     = last_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    ld_ready_o = 1'b0;
    start_o    = 1'b0;
    we_o       = 1'b0;

    case (state_q)
      LD_IDLE: begin
        ld_ready_o = 1'b1;
        if (ld_valid_i) begin
          lo_d    = ld_data_i;
          count_d = '0;
          if (ld_last_i) begin
            hi_d    = 8'h00;
            last_d  = 1'b1;
            state_d = LD_COMMIT;
          end else begin
            last_d     = 1'b0;
            lo_phase_d = 1'b0;
            state_d    = LD_HI;
          end
        end
      end

      // LD_HI doubles as the low-byte wait between words of one image
      LD_HI: begin
        ld_ready_o = 1'b1;
        if (ld_valid_i) begin
          if (lo_phase_q) begin
            lo_d = ld_data_i;
            if (ld_last_i) begin
              hi_d    = 8'h00;
              last_d  = 1'b1;
              state_d = LD_COMMIT;
            end else begin
              lo_phase_d = 1'b0;
            end
          end else begin
            hi_d    = ld_data_i;
            last_d  = ld_last_i;
            state_d = LD_COMMIT;
          end
        end
      end

      LD_COMMIT: begin
        we_o    = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        count_d = count_q + 1'b1;
        if (ptr_q == '1) begin
          ovf_d = 1'b1;
        end
        if (last_q) begin
          state_d = LD_DONE;
        end else begin
          lo_phase_d = 1'b1;
          state_d    = LD_HI;
        end
      end

      LD_DONE: begin
        start_o = 1'b1;
        ptr_d   = '0;
        state_d = LD_IDLE;
      end

      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  assign ld_busy_o  = (state_q != LD_IDLE);
  assign ld_count_o = count_q;
  assign ld_ovf_o   = ovf_q;
  assign waddr_o    = ptr_q;
  assign wdata_o    = {hi_q, lo_q};

endmodule

// File: rtl/pcpu_mem_responder.sv
// PCPU memory responder: instruction/data memories with asynchronous reads
// and a byte loader. Option: PCPU_MEM_IFETCH_GUARD_EN fetches HALT while loading.
module pcpu_mem_responder
  import pcpu_mem_responder_pkg::*;
#(
  parameter int IADDR_W = IADDR_W_DEF,
  parameter int DADDR_W = DADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [IADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0]  i_datain,
  input  logic [DADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0]  d_dataout,
  input  logic               d_we,
  output logic [DATA_W-1:0]  d_datain,
  input  logic               ld_valid,
  input  logic [7:0]         ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               ld_busy,
  output logic [IADDR_W:0]   ld_count,
  output logic               ld_ovf,
  output logic               start
);

  localparam int IDEPTH = 1 << IADDR_W;
  localparam int DDEPTH = 1 << DADDR_W;

  logic [DATA_W-1:0]  imem_q [IDEPTH];
  logic [DATA_W-1:0]  dmem_q [DDEPTH];

  logic               ld_we;
  logic [IADDR_W-1:0] ld_waddr;
  logic [DATA_W-1:0]  ld_wdata;

  pcpu_loader #(
    .IADDR_W (IADDR_W)
  ) u_loader (
    .clock      (clock),
    .reset      (reset),
    .ld_valid_i (ld_valid),
    .ld_data_i  (ld_data),
    .ld_last_i  (ld_last),
    .ld_ready_o (ld_ready),
    .ld_busy_o  (ld_busy),
    .ld_count_o (ld_count),
    .ld_ovf_o   (ld_ovf),
    .start_o    (start),
    .we_o       (ld_we),
    .waddr_o    (ld_waddr),
    .wdata_o    (ld_wdata)
  );

  // Memories are deliberately left out of reset so images survive it
  always_ff @(posedge clock) begin
    if (ld_we) begin
      imem_q[ld_waddr] <= ld_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (d_we && !ld_busy) begin
      dmem_q[d_addr] <= d_dataout;
    end
  end

  assign d_datain = dmem_q[d_addr];

`ifdef PCPU_MEM_IFETCH_GUARD_EN
  assign i_datain = ld_busy ? HALT_WORD : imem_q[i_addr];
`else
  assign i_datain = imem_q[i_addr];
`endif

endmodule

// File: tb/tb_pcpu_mem_responder.sv
// Directed self-checking bench for pcpu_mem_responder.
`timescale 1ns/1ps
module tb_pcpu_mem_responder;

`ifdef PCPU_MEM_IFETCH_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [7:0]  i_addr;
  logic [15:0] i_datain;
  logic [7:0]  d_addr;
  logic [15:0] d_dataout;
  logic        d_we;
  logic [15:0] d_datain;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_busy;
  logic [8:0]  ld_count;
  logic        ld_ovf;
  logic        start;

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;
  int base;
  logic [15:0] w;

  pcpu_mem_responder dut (
    .clock     (clock),
    .reset     (reset),
    .i_addr    (i_addr),
    .i_datain  (i_datain),
    .d_addr    (d_addr),
    .d_dataout (d_dataout),
    .d_we      (d_we),
    .d_datain  (d_datain),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_busy   (ld_busy),
    .ld_count  (ld_count),
    .ld_ovf    (ld_ovf),
    .start     (start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (start === 1'b1) start_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    ld_last  = last;
    while (!acc && guard < 20) begin
      acc = ld_ready;
      @(posedge clock);
      #1;
      guard++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("ld_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic chk_imem(input string tag, input logic [7:0] a, input logic [15:0] exp);
    i_addr = a;
    #1;
    chk(tag, {16'd0, i_datain}, {16'd0, exp});
  endtask

  function automatic logic [15:0] fetch_exp(input logic busy_now, input logic [15:0] mem);
    return (GUARD && busy_now) ? 16'h0800 : mem;
  endfunction

  initial begin
    reset = 1'b1; i_addr = 8'h00; d_addr = 8'h00; d_dataout = 16'h0000; d_we = 1'b0;
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    #12;
    chk("rst_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_busy",  {31'd0, ld_busy},  32'd0);
    chk("rst_count", {23'd0, ld_count}, 32'd0);
    chk("rst_ovf",   {31'd0, ld_ovf},   32'd0);
    chk("rst_start", {31'd0, start},    32'd0);
    reset = 1'b0;
    step();

    // Even-length image: 00 08 01 0A
    base = start_cnt;
    send_byte(8'h00, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h0A, 1'b1);
    chk("t1_busy_commit", {31'd0, ld_busy}, 32'd1);
    chk("t1_start_commit", {31'd0, start}, 32'd0);
    step();
    chk("t1_start_done", {31'd0, start}, 32'd1);
    step();
    chk("t1_start_idle", {31'd0, start}, 32'd0);
    chk("t1_busy_idle", {31'd0, ld_busy}, 32'd0);
    chk("t1_count", {23'd0, ld_count}, 32'd2);
    chk("t1_start_pulses", start_cnt - base, 32'd1);
    chk_imem("t1_imem0", 8'd0, 16'h0800);
    chk_imem("t1_imem1", 8'd1, 16'h0A01);
    step();

    // Odd-length image: 34 12 56
    base = start_cnt;
    send_byte(8'h34, 1'b0);
    chk("t2_count_cleared", {23'd0, ld_count}, 32'd0);
    chk("t2_busy", {31'd0, ld_busy}, 32'd1);
    chk_imem("t2_fetch_during_load", 8'd1, fetch_exp(1'b1, 16'h0A01));
    send_byte(8'h12, 1'b0);
    send_byte(8'h56, 1'b1);
    chk_imem("t2_fetch_before_commit", 8'd1, fetch_exp(1'b1, 16'h0A01));
    step();
    chk_imem("t2_fetch_after_commit", 8'd1, fetch_exp(1'b1, 16'h0056));
    chk("t2_start_done", {31'd0, start}, 32'd1);
    step();
    chk("t2_busy_idle", {31'd0, ld_busy}, 32'd0);
    chk("t2_count", {23'd0, ld_count}, 32'd2);
    chk("t2_start_pulses", start_cnt - base, 32'd1);
    chk_imem("t2_imem0", 8'd0, 16'h1234);
    chk_imem("t2_imem1", 8'd1, 16'h0056);
    step();

    // Data port: write, same-cycle old value, write blocked while loading
    d_addr = 8'h0B; d_dataout = 16'h1111; d_we = 1'b1;
    step();
    d_dataout = 16'h011B;
    #1;
    chk("t3_same_cycle_old", {16'd0, d_datain}, 32'h1111);
    step();
    d_we = 1'b0;
    #1;
    chk("t3_write", {16'd0, d_datain}, 32'h011B);
    send_byte(8'hAA, 1'b0);
    chk("t3_busy", {31'd0, ld_busy}, 32'd1);
    d_dataout = 16'hBEEF; d_we = 1'b1;
    step();
    d_we = 1'b0;
    #1;
    chk("t3_write_blocked", {16'd0, d_datain}, 32'h011B);
    send_byte(8'hBB, 1'b1);
    step();
    step();
    chk("t3_busy_idle", {31'd0, ld_busy}, 32'd0);
    chk_imem("t3_imem0", 8'd0, 16'hBBAA);
    step();

    // 257 words with no last byte: pointer wraps, word 256 lands at 0
    for (int k = 0; k <= 256; k++) begin
      w = 16'h1000 + k[15:0];
      if (k == 256) chk("t4_ovf_before_wrap", {31'd0, ld_ovf}, 32'd0);
      send_byte(w[7:0], 1'b0);
      send_byte(w[15:8], 1'b0);
    end
    step();
    chk("t4_ovf", {31'd0, ld_ovf}, 32'd1);
    chk("t4_count", {23'd0, ld_count}, 32'd257);
    chk("t4_busy", {31'd0, ld_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t4_rst_busy", {31'd0, ld_busy}, 32'd0);
    chk("t4_rst_ovf", {31'd0, ld_ovf}, 32'd0);
    #4;
    reset = 1'b0;
    step();
    chk_imem("t4_imem0_word256", 8'd0, 16'h1100);
    chk_imem("t4_imem1_word1", 8'd1, 16'h1001);
    step();

    // Reset after the low byte of word 3
    base = start_cnt;
    for (int k = 0; k < 3; k++) begin
      w = 16'h2000 + k[15:0];
      send_byte(w[7:0], 1'b0);
      send_byte(w[15:8], 1'b0);
    end
    send_byte(8'h03, 1'b0);
    chk("t5_busy", {31'd0, ld_busy}, 32'd1);
    chk_imem("t5_fetch_during_load", 8'd5, fetch_exp(1'b1, 16'h1005));
    reset = 1'b1;
    #1;
    chk("t5_rst_busy", {31'd0, ld_busy}, 32'd0);
    chk("t5_rst_ready", {31'd0, ld_ready}, 32'd1);
    chk("t5_rst_count", {23'd0, ld_count}, 32'd0);
    step();
    reset = 1'b0;
    step();
    step();
    step();
    chk("t5_no_start", start_cnt - base, 32'd0);
    chk("t5_busy_after", {31'd0, ld_busy}, 32'd0);
    chk_imem("t5_imem0", 8'd0, 16'h2000);
    chk_imem("t5_imem1", 8'd1, 16'h2001);
    chk_imem("t5_imem2", 8'd2, 16'h2002);
    step();
    chk_imem("t5_imem3_partial_dropped", 8'd3, 16'h1003);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcpu_mem_responder.md
# pcpu_mem_responder

Memory-side responder for the PCPU instruction and data ports: serves instruction fetches on `i_addr`, serves data reads and accepts data writes on `d_addr`/`d_dataout`/`d_we`. It holds a 256×16 instruction memory and a 256×16 data memory. It also contains a byte-serial loader that fills instruction memory, then pulses the CPU `start` input. It sits between the PCPU core and the board/test harness and replaces hand-driven `i_datain`/`d_datain` stimulus.

## Interface
Parameters:
- `IADDR_W`, 8, instruction address width; instruction memory depth is 2^IADDR_W.
- `DADDR_W`, 8, data address width; data memory depth is 2^DADDR_W.
- `DATA_W`, 16, word width (fixed at 16 for the loader byte split).

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `i_addr`  in  IADDR_W  fetch address from CPU.
- `i_datain`  out  DATA_W  instruction word to CPU.
- `d_addr`  in  DADDR_W  data address from CPU.
- `d_dataout`  in  DATA_W  CPU write data.
- `d_we`  in  1  CPU write enable.
- `d_datain`  out  DATA_W  read data to CPU.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  8  loader byte.
- `ld_last`  in  1  marks final byte of image; qualified by `ld_valid`.
- `ld_ready`  out  1  loader can accept a byte.
- `ld_busy`  out  1  load in progress; the state is not IDLE.
- `ld_count`  out  IADDR_W+1  words committed in current or last load.
- `ld_ovf`  out  1  sticky: image exceeded memory depth.
- `start`  out  1  one-cycle pulse to CPU `start` after a load completes.

## Operation
- Reads are asynchronous: `i_datain = imem[i_addr]`, `d_datain = dmem[d_addr]`.
- Data writes: on the clock edge, `dmem[d_addr] <= d_dataout` when `d_we`.
  - A read of the same address in the same cycle returns the old value.
  - Writes are ignored while `ld_busy`.
- Memory contents are not cleared by reset.
- Loader FSM states: IDLE, HI, COMMIT, DONE.
  - IDLE: `ld_ready=1`. A byte is accepted when `ld_valid && ld_ready`; the accepted byte is the low byte. Go to HI. If `ld_last` is set on this byte, the high byte is 0x00 and the FSM goes to COMMIT.
  - HI: `ld_ready=1`. The accepted byte is the high byte. Go to COMMIT. Remember `ld_last`.
  - COMMIT: `ld_ready=0`. Write `imem[ptr] <= {hi,lo}`, then `ptr++` and `ld_count++`. Go to DONE if last was seen, else go to HI-wait-low, i.e. back to accepting the low byte (an internal LO phase of HI).
  - DONE: `ld_ready=0`, `start=1` for exactly this cycle. Then go to IDLE and clear `ptr` to 0.
- Word order is little-endian: the low byte comes first.
- `ld_count` resets to 0 on the first byte of a new load and holds its value after DONE.
- Wrap-around: committing at `ptr=2^IADDR_W-1` wraps `ptr` to 0 and sets `ld_ovf`, which stays set until reset. Loading continues.
- If `ld_valid` is held high, one byte is accepted per ready cycle. Bytes presented while `ld_ready=0` are not consumed and must be held.

## Timing
- Reset values: `ld_ready=1`, `ld_busy=0`, `ld_count=0`, `ld_ovf=0`, `start=0`, FSM=IDLE, `ptr=0`. `i_datain` and `d_datain` follow memory combinationally.
- Per word: 2 accept cycles plus 1 COMMIT cycle, so the maximum throughput is 1 word per 3 cycles.
- `start` is asserted in the cycle after the final COMMIT. A word written in COMMIT is visible on `i_datain` in the next cycle.
- A reset in the middle of a load returns the FSM to IDLE immediately. A partial word is discarded, and words already committed remain in memory.

## Configuration
- `PCPU_MEM_IFETCH_GUARD_EN` defined: while `ld_busy`, `i_datain` is forced to `HALT_WORD`, so the CPU cannot execute a partially loaded image.
- Not defined: `i_datain` always reads `imem[i_addr]` directly.

## Structure
- Shared package/defines:
  - `HALT_WORD` = {`HALT, 11'b0}.
  - The loader state encoding.
  - `IADDR_W`/`DADDR_W` defaults, shared with PCPU.
- One sub-module: `pcpu_loader`, containing the FSM, pointer, count, ovf and start logic. It outputs a write port to the memories. The memories and read muxing stay in the top module.

## Test plan
- Load bytes 00,08,01,0A with `ld_last` on the 4th byte. Then imem[0]=0x0800, imem[1]=0x0A01, `ld_count`=2, and `start` pulses once, 1 cycle after the second COMMIT.
- Odd-length load: 3 bytes 34,12,56 with last on 56. Then imem[1]=0x0056, `ld_count`=2.
- Data path:
  - `d_we=1`, `d_addr=0x0B`, `d_dataout=0x011B` for one cycle. Next cycle `d_datain=0x011B` at `d_addr=0x0B`.
  - Same-cycle read of that address returns the old value.
  - A write attempted while `ld_busy` leaves dmem unchanged.
- Stream 257 words without `ld_last`. Then `ld_ovf`=1, imem[0] holds word 256, and `ld_count` wraps per its width (257).
- Assert `reset` after the low byte of word 3. Then the FSM returns to IDLE, `ld_busy`=0, `start` never pulses, and imem[0..2] are retained.
- With `PCPU_MEM_IFETCH_GUARD_EN`: during the load `i_datain`=`HALT_WORD` for any `i_addr`. Without it, `i_datain` tracks imem.
